// File: rtl/bsg_dff_chain_elastic.sv
// bsg_dff_chain_elastic
// Fixed-latency retiming pipe of num_stages_p registered stages with a valid
// bit per stage. The input side uses ready/valid and the output side uses
// valid/yumi. Stages advance into free slots, so bubbles are squeezed out
// when the consumer stalls and no item is ever dropped. flush_i clears every
// valid bit and leaves the payloads alone. count_o reports how many stages
// currently hold data.
module bsg_dff_chain_elastic #(
    parameter int width_p      = 16,
    parameter int num_stages_p = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  flush_i,
    input  logic                                  v_i,
    input  logic [width_p-1:0]                    data_i,
    output logic                                  ready_o,
    output logic                                  v_o,
    output logic [width_p-1:0]                    data_o,
    input  logic                                  yumi_i,
    output logic [$clog2(num_stages_p+1)-1:0]     count_o
);

    localparam int count_w_lp = $clog2(num_stages_p + 1);

    // Refuse to build a chain with no stages or a zero-width payload
    if (num_stages_p < 1) begin : g_bad_stages
        $error("bsg_dff_chain_elastic: num_stages_p must be >= 1");
    end
    if (width_p < 1) begin : g_bad_width
        $error("bsg_dff_chain_elastic: width_p must be >= 1");
    end

    // Stage 0 is the input end, stage num_stages_p-1 drives the outputs
    logic [num_stages_p-1:0] v_q;
    logic [num_stages_p-1:0] v_d;
    logic [width_p-1:0]      data_q [num_stages_p];
    logic [width_p-1:0]      data_d [num_stages_p];

    // adv[k]: stage k hands its item onward this cycle
    // load[k]: stage k captures a new item this cycle
    logic [num_stages_p-1:0] adv;
    logic [num_stages_p-1:0] load;

    // Advance chain, resolved from the output end back toward the input so a
    // yumi on a full pipe lets every stage move at once
    always_comb begin
        adv = '0;
        adv[num_stages_p-1] = v_q[num_stages_p-1] & yumi_i;
        for (int k = num_stages_p - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
    end

    // Stage 0 can take an item if it is empty or emptying this cycle
    assign ready_o = ~reset_i & ~flush_i & (~v_q[0] | adv[0]);

    // Each stage loads from its upstream neighbour; stage 0 loads from the input
    always_comb begin
        load = '0;
        load[0] = v_i & ready_o;
        for (int k = 1; k < num_stages_p; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Next-state for valids and payloads; flush empties the pipe but keeps data
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush_i) begin
            v_d = '0;
        end else begin
            for (int k = 0; k < num_stages_p; k++) begin
                v_d[k] = load[k] | (v_q[k] & ~adv[k]);
            end
            if (load[0]) begin
                data_d[0] = data_i;
            end
            for (int k = 1; k < num_stages_p; k++) begin
                if (load[k]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Stage registers with synchronous reset clearing valids and payloads
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q <= '0;
            for (int k = 0; k < num_stages_p; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q[num_stages_p-1];
    assign data_o = data_q[num_stages_p-1];

    // Occupancy is the population count of the stage valid bits
    always_comb begin
        count_o = '0;
        for (int k = 0; k < num_stages_p; k++) begin
            count_o = count_o + count_w_lp'(v_q[k]);
        end
    end

endmodule

// File: tb/tb_bsg_dff_chain_elastic.sv
// Bench for bsg_dff_chain_elastic (width 16, 4 stages). A FIFO scoreboard
// stamps each accepted item with its acceptance edge; the oldest item must
// sit on the output once it is num_stages-1 edges old, and the occupancy
// equals the number of items held. A constant vector table covers the bubble
// collapse and flush cases; short directed sequences and a random phase follow.
module tb_bsg_dff_chain_elastic;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk;
    logic          reset_i;
    logic          flush_i;
    logic          v_i;
    logic [W-1:0]  data_i;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic [2:0]    count_o;

    bsg_dff_chain_elastic #(.width_p(W), .num_stages_p(N)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    logic  sampled_ready;
    logic  last_accept;
    logic  last_yumi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_vo();
        return (q.size() > 0) && ((cyc - q[0].t) >= N - 1);
    endfunction

    // One clock cycle: drive inputs, check ready_o, advance model, check outputs
    task automatic do_cycle(input logic rst, input logic fl, input logic v,
                            input logic [W-1:0] d, input logic y_req);
        logic exp_ready;
        logic y;
        y = y_req & model_vo();
        reset_i = rst;
        flush_i = fl;
        v_i     = v;
        data_i  = d;
        yumi_i  = y;
        #1;
        exp_ready = !rst && !fl && ((q.size() < N) || y);
        sampled_ready = ready_o;
        chk("ready_o", ready_o, exp_ready);
        @(posedge clk);
        cyc++;
        last_accept = 1'b0;
        last_yumi   = y;
        if (rst) begin
            q.delete();
        end else begin
            if (y) void'(q.pop_front());
            if (fl) begin
                q.delete();
            end else if (v && exp_ready) begin
                q.push_back('{d: d, t: cyc});
                last_accept = 1'b1;
            end
        end
        #1;
        chk("count_o", count_o, q.size());
        chk("v_o", v_o, model_vo());
        if (model_vo()) chk("data_o", data_o, q[0].d);
    endtask

    typedef struct {
        logic         rst, fl, v;
        logic [W-1:0] d;
        logic         y;
        logic         e_ready, e_vo, chk_d;
        logic [W-1:0] e_d;
        int           e_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int idx, first_acc, first_out, last_out, nexp, got;

        reset_i = 1'b1; flush_i = 1'b0; v_i = 1'b0; data_i = '0; yumi_i = 1'b0;

        //            rst  fl   v    d        y    rdy  vo   chkd e_d      cnt
        tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1,16'h0000,0};
        tbl[1]  = '{1'b0,1'b0,1'b1,16'h1111,1'b0,1'b1,1'b0,1'b0,16'h0000,1};
        tbl[2]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0000,1};
        tbl[3]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0000,1};
        tbl[4]  = '{1'b0,1'b0,1'b1,16'h2222,1'b0,1'b1,1'b1,1'b1,16'h1111,2};
        tbl[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b1,16'h1111,2};
        tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b1,1'b1,16'h1111,2};
        tbl[7]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1,1'b1,16'h2222,1};
        tbl[8]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0,1'b0,16'h0000,0};
        tbl[9]  = '{1'b0,1'b0,1'b1,16'h0301,1'b0,1'b1,1'b0,1'b0,16'h0000,1};
        tbl[10] = '{1'b0,1'b0,1'b1,16'h0302,1'b0,1'b1,1'b0,1'b0,16'h0000,2};
        tbl[11] = '{1'b0,1'b0,1'b1,16'h0303,1'b0,1'b1,1'b0,1'b0,16'h0000,3};
        tbl[12] = '{1'b0,1'b1,1'b1,16'hBEEF,1'b0,1'b0,1'b0,1'b0,16'h0000,0};
        for (int i = 13; i < 17; i++)
            tbl[i] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0000,0};

        // Table: reset, bubble collapse, flush with a refused 0xBEEF
        for (int i = 0; i < 17; i++) begin
            do_cycle(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].y);
            chk("tbl_ready", sampled_ready, tbl[i].e_ready);
            chk("tbl_count", count_o, tbl[i].e_cnt);
            chk("tbl_v_o", v_o, tbl[i].e_vo);
            if (tbl[i].chk_d) chk("tbl_data_o", data_o, tbl[i].e_d);
            $display("vec %0d: rst=%0b fl=%0b v=%0b d=%h y=%0b -> ready=%0b v_o=%0b data_o=%h count=%0d",
                     i, tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].y,
                     sampled_ready, v_o, data_o, count_o);
        end

        // Streaming 0x0001..0x0010 with yumi following v_o
        idx = 1; first_acc = -1; first_out = -1; last_out = -1; nexp = 1;
        for (int c = 0; c < 40 && (idx <= 16 || q.size() > 0); c++) begin
            if (v_o) begin
                chk("stream_data", data_o, nexp);
                nexp++;
            end
            do_cycle(1'b0, 1'b0, idx <= 16, W'(idx), 1'b1);
            if (idx <= 16) chk("stream_ready", sampled_ready, 1'b1);
            if (last_accept) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (v_o) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
        end
        chk("stream_latency", first_out - first_acc, N - 1);
        chk("stream_span", last_out - first_out, 15);
        chk("stream_count", nexp - 1, 16);
        $display("stream: first accept %0d, first out %0d, last out %0d", first_acc, first_out, last_out);

        // Backpressure fill then release
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            do_cycle(1'b0, 1'b0, 1'b1, 16'hA000 + W'(idx), 1'b0);
            if (last_accept) idx++;
        end
        chk("bp_accepted", idx, 4);
        chk("bp_count", count_o, 4);
        chk("bp_ready_full", sampled_ready, 1'b0);
        chk("bp_head", data_o, 16'hA000);
        do_cycle(1'b0, 1'b0, 1'b1, 16'hA004, 1'b1);
        chk("bp_ready_yumi", sampled_ready, 1'b1);
        chk("bp_accept_yumi", last_accept, 1'b1);
        chk("bp_count_keep", count_o, 4);
        chk("bp_next", data_o, 16'hA001);
        do_cycle(1'b0, 1'b0, 1'b1, 16'hA005, 1'b1);
        for (int c = 0; c < 12 && q.size() > 0; c++) do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("bp_drained", count_o, 0);
        $display("backpressure: accepted %0d before release, drained", idx);

        // Reset mid-stream with a full pipe, then 0x5A5A latency
        for (int c = 0; c < 5; c++) do_cycle(1'b0, 1'b0, 1'b1, 16'h7000 + W'(c), 1'b0);
        chk("rst_full_count", count_o, 4);
        do_cycle(1'b1, 1'b0, 1'b1, 16'h7777, 1'b1);
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_data_o", data_o, 16'h0000);
        chk("rst_count", count_o, 0);
        do_cycle(1'b0, 1'b0, 1'b1, 16'h5A5A, 1'b0);
        chk("post_rst_accept", last_accept, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            chk("post_rst_v_o", v_o, c == 3);
        end
        chk("post_rst_data", data_o, 16'h5A5A);
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        $display("reset mid-stream: 0x5A5A emerged after %0d edges", N - 1);

        // Random traffic against the scoreboard
        got = 0;
        for (int c = 0; c < 10000; c++) begin
            do_cycle($urandom_range(0, 1023) == 0, $urandom_range(0, 63) == 0,
                     1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0);
            if (last_yumi) got++;
        end
        $display("random: 10000 cycles, %0d items delivered", got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
